// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive front end: frame FSM encoding and
// the oversample index at which every per-bit decision is taken.
package uart_pkg;

  // Four base states fit two bits; STOP extends the encoding to a third bit.
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b010,
    PARITY = 3'b011,
    STOP   = 3'b100
  } state_e;

  // Decision edge: two clocks after mid-bit, once the majority vote has settled.
  function automatic int unsigned chk_edge(input int unsigned prescale);
    return prescale / 2 + 2;
  endfunction

endpackage

// File: rtl/uart_rx_data_sampler.sv
// Three-sample majority voter around the middle of each oversampled bit.
module uart_rx_data_sampler #(
  parameter int PRESCALE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] edge_count,
  input  logic       RX_IN,
  output logic       sampled_bit
);

  localparam logic [4:0] S0_EC = 5'(PRESCALE / 2 - 1);
  localparam logic [4:0] S1_EC = 5'(PRESCALE / 2);
  localparam logic [4:0] VT_EC = 5'(PRESCALE / 2 + 1);

  logic s0_q, s1_q, bit_q;

  // Capture two samples, then vote with the live third sample one edge later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s0_q  <= 1'b0;
      s1_q  <= 1'b0;
      bit_q <= 1'b0;
    end else begin
      if (edge_count == S0_EC) s0_q <= RX_IN;
      if (edge_count == S1_EC) s1_q <= RX_IN;
      if (edge_count == VT_EC) bit_q <= (s0_q & s1_q) | (s0_q & RX_IN) | (s1_q & RX_IN);
    end
  end

  assign sampled_bit = bit_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detection, edge/bit counting, frame FSM,
// deserializer gating and parity/stop checking.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int PRESCALE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic [7:0] P_DATA,
  output logic       sampled_bit,
  output logic [4:0] edge_count,
  output logic       deser_en,
  output logic       data_valid,
  output logic       par_err,
  output logic       stp_err
);

  localparam logic [4:0] CHK  = 5'(chk_edge(PRESCALE));
  localparam logic [4:0] LAST = 5'(PRESCALE - 1);

  state_e     state_q;
  logic [4:0] ec_q;
  logic [2:0] bit_cnt_q;
  logic       par_en_q, par_typ_q;
  logic       par_err_q, stp_err_q, dv_q;

  logic at_chk, wrap;
  assign at_chk = (ec_q == CHK);
  assign wrap   = (ec_q == LAST);

  uart_rx_data_sampler #(.PRESCALE(PRESCALE)) u_sampler (
    .clk         (clk),
    .rst         (rst),
    .edge_count  (ec_q),
    .RX_IN       (RX_IN),
    .sampled_bit (sampled_bit)
  );

  // Frame FSM with the edge/bit counters and registered status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      ec_q      <= '0;
      bit_cnt_q <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
      dv_q      <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      if (state_q == IDLE) ec_q <= '0;
      else                 ec_q <= wrap ? 5'd0 : ec_q + 5'd1;
      case (state_q)
        IDLE: begin
          if (!RX_IN) begin
            state_q   <= START;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
          end
        end
        START: begin
          // A start bit that votes high was a glitch.
          if (at_chk && sampled_bit) begin
            state_q <= IDLE;
            ec_q    <= '0;
          end else if (wrap) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          if (wrap) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_q <= '0;
              state_q   <= par_en_q ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (at_chk) par_err_q <= sampled_bit ^ (^P_DATA) ^ par_typ_q;
          if (wrap)   state_q   <= STOP;
        end
        STOP: begin
          // Leave at the decision edge so a following start bit is seen on time.
          if (at_chk) begin
            stp_err_q <= ~sampled_bit;
            dv_q      <= sampled_bit & ~par_err_q;
            state_q   <= IDLE;
            ec_q      <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign edge_count = ec_q;
  assign deser_en   = (state_q == DATA);
  assign data_valid = dv_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule
